// File: rtl/matrix_pkg.sv
// Shared definitions for the 8x8 LED matrix scan path (frame controller and driver).
package matrix_pkg;
  localparam int MATRIX_COLS = 8;
  localparam int MATRIX_ROWS = 8;
  localparam int FRAME_W     = MATRIX_COLS * MATRIX_ROWS;
  localparam int COL_W       = $clog2(MATRIX_COLS);

  typedef enum logic {IDLE, SCAN} scan_state_t;
endpackage

// File: rtl/matrix_ce_gen.sv
// Prescaler producing a registered one-cycle clock-enable every DIV cycles while enabled.
module matrix_ce_gen #(
  parameter int DIV = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic ce
);
  localparam int PW = (DIV >= 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_chk
    $error("matrix_ce_gen: DIV must be >= 2");
  end

  logic [PW-1:0] pcnt;
  logic          wrap;

  assign wrap = (pcnt == PW'(DIV - 1));

  // Disable beats a coincident wrap: no strobe leaks out on the cycle EN falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      ce   <= 1'b0;
    end else if (!en) begin
      pcnt <= '0;
      ce   <= 1'b0;
    end else begin
      ce   <= wrap;
      pcnt <= wrap ? '0 : pcnt + PW'(1);
    end
  end
endmodule

// File: rtl/matrix_frame_ctrl.sv
// Column-scan frame scheduler: column strobe, column position and tear-free double buffering.
module matrix_frame_ctrl
  import matrix_pkg::*;
#(
  parameter int CLK_REF = 48_000_000,
  parameter int CLK_CE  = 1_000_000,
  parameter int DIV     = CLK_REF / CLK_CE
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic               WR_VALID,
  input  logic [FRAME_W-1:0] WR_DATA,
  output logic               WR_READY,
  output logic               CE_O,
  output logic [COL_W-1:0]   COL_O,
  output logic [FRAME_W-1:0] DAT_O,
  output logic               FRAME_O
);
  scan_state_t        state, state_nxt;
  logic               scan;
  logic               hs;
  logic               pending;
  logic [FRAME_W-1:0] shadow;
  logic [FRAME_W-1:0] active;

  matrix_ce_gen #(.DIV(DIV)) u_ce_gen (
    .clk (CLK),
    .rst (RST),
    .en  (EN),
    .ce  (CE_O)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    scan      = 1'b0;
    case (state)
      IDLE: if (EN) state_nxt = SCAN;
      SCAN: begin
        scan = EN;
        if (!EN) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Position is discarded whenever scanning stops; the next scan starts at column 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              COL_O <= '0;
    else if (!EN)         COL_O <= '0;
    else if (CE_O && scan) COL_O <= COL_O + COL_W'(1);
  end

  assign FRAME_O  = CE_O & (COL_O == COL_W'(MATRIX_COLS - 1));
  assign WR_READY = ~pending;
  assign hs       = WR_VALID & ~pending;
  assign DAT_O    = active;

  // A handshake landing on a boundary only sets pending; the swap looks at the old flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (hs) shadow <= WR_DATA;
      if (FRAME_O && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (hs) begin
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_matrix_frame_ctrl.sv
// Directed bench for matrix_frame_ctrl with DIV = 8 and a queue scoreboard on DAT_O.
module tb_matrix_frame_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic        WR_VALID = 1'b0;
  logic [63:0] WR_DATA = '0;
  logic        WR_READY, CE_O, FRAME_O;
  logic [2:0]  COL_O;
  logic [63:0] DAT_O;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [63:0] sb[$];
  logic [63:0] prev_dat = '0;

  localparam logic [63:0] FX = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] FA = 64'hAAAA_0000_5555_1111;
  localparam logic [63:0] FB = 64'hBBBB_2222_6666_3333;
  localparam logic [63:0] FC = 64'hC0C0_1234_C0C0_5678;
  localparam logic [63:0] FE = 64'hEEEE_9999_7777_4444;

  matrix_frame_ctrl #(.CLK_REF(8), .CLK_CE(1)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .WR_VALID(WR_VALID), .WR_DATA(WR_DATA),
    .WR_READY(WR_READY), .CE_O(CE_O), .COL_O(COL_O), .DAT_O(DAT_O), .FRAME_O(FRAME_O)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock; a handshake seen at the edge pushes its frame onto the scoreboard.
  task automatic tick();
    logic hs;
    logic [63:0] d;
    hs = WR_VALID && WR_READY && !RST;
    d  = WR_DATA;
    @(posedge CLK);
    #1;
    cyc++;
    if (hs) sb.push_back(d);
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    RST = 1'b1; EN = 1'b0; WR_VALID = 1'b0;
    sb.delete();
    tick(); tick();
    RST = 1'b0; EN = 1'b1; cyc = 0;
  endtask

  // DAT_O may only change to the oldest accepted, not-yet-shown frame.
  always @(negedge CLK) begin
    if (RST) prev_dat = '0;
    else if (DAT_O !== prev_dat) begin
      if (sb.size() == 0) chk("sb_unexpected", DAT_O, prev_dat);
      else chk("sb_dat", DAT_O, sb.pop_front());
      prev_dat = DAT_O;
    end
  end

  initial begin
    // Reset values, then one full frame with a single write.
    do_reset();
    chk("rst_ce", CE_O, 0);
    chk("rst_col", COL_O, 0);
    chk("rst_frame", FRAME_O, 0);
    chk("rst_dat", DAT_O, 0);
    chk("rst_rdy", WR_READY, 1);
    for (int i = 1; i <= 72; i++) begin
      tick();
      chk("ce_period", CE_O, (cyc % 8) == 0);
      chk("col_seq", COL_O, ((cyc - 1) / 8) % 8);
      chk("frame_pulse", FRAME_O, (cyc % 64) == 0);
      if (cyc == 10) begin WR_VALID = 1'b1; WR_DATA = FX; end
      if (cyc == 11) begin WR_VALID = 1'b0; chk("rdy_low", WR_READY, 0); end
      if (cyc == 64) chk("dat_before_swap", DAT_O, 0);
      if (cyc == 65) begin chk("dat_swap", DAT_O, FX); chk("rdy_back", WR_READY, 1); end
    end

    // Mid-frame reset with a pending frame: it must be dropped.
    WR_VALID = 1'b1; WR_DATA = FE;
    tick();
    WR_VALID = 1'b0;
    chk("rdy_pend", WR_READY, 0);
    run_to(84);
    sb.delete();
    #2 RST = 1'b1;
    #1;
    chk("arst_dat", DAT_O, 0);
    chk("arst_rdy", WR_READY, 1);
    chk("arst_col", COL_O, 0);
    chk("arst_ce", CE_O, 0);
    tick();
    RST = 1'b0; EN = 1'b1; cyc = 0;
    run_to(65);
    chk("lost_dat1", DAT_O, 0);
    run_to(129);
    chk("lost_dat2", DAT_O, 0);
    chk("lost_rdy", WR_READY, 1);

    // Held WR_VALID: A then B, B accepted only after the first swap.
    do_reset();
    run_to(10);
    WR_VALID = 1'b1; WR_DATA = FA;
    tick();
    WR_DATA = FB;
    chk("hold_rdy11", WR_READY, 0);
    run_to(64);
    chk("hold_rdy64", WR_READY, 0);
    chk("hold_dat64", DAT_O, 0);
    tick();
    chk("hold_dat65", DAT_O, FA);
    chk("hold_rdy65", WR_READY, 1);
    tick();
    chk("hold_rdy66", WR_READY, 0);
    WR_VALID = 1'b0;
    run_to(128);
    chk("hold_dat128", DAT_O, FA);
    tick();
    chk("hold_dat129", DAT_O, FB);

    // Handshake on the boundary edge with pending = 0: shown one frame later.
    do_reset();
    run_to(64);
    chk("coll_frame", FRAME_O, 1);
    WR_VALID = 1'b1; WR_DATA = FC;
    tick();
    WR_VALID = 1'b0;
    chk("coll_dat65", DAT_O, 0);
    chk("coll_rdy65", WR_READY, 0);
    run_to(128);
    chk("coll_frame128", FRAME_O, 1);
    chk("coll_dat128", DAT_O, 0);
    tick();
    chk("coll_dat129", DAT_O, FC);
    chk("coll_rdy129", WR_READY, 1);

    // EN gap: no strobes, column restarts at 0, first CE_O DIV cycles after resume.
    do_reset();
    run_to(30);
    chk("gap_col30", COL_O, 3);
    EN = 1'b0;
    for (int i = 31; i <= 40; i++) begin
      tick();
      chk("gap_ce", CE_O, 0);
      chk("gap_col", COL_O, 0);
    end
    EN = 1'b1;
    for (int i = 41; i <= 47; i++) begin
      tick();
      chk("resume_ce_quiet", CE_O, 0);
    end
    tick();
    chk("resume_ce48", CE_O, 1);
    chk("resume_col48", COL_O, 0);
    tick();
    chk("resume_col49", COL_O, 1);
    run_to(55);
    EN = 1'b0;
    tick();
    chk("en_wins_ce", CE_O, 0);
    chk("en_wins_frame", FRAME_O, 0);
    chk("en_wins_col", COL_O, 0);

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
